hsid_obi_pixel_responder: RTL and testbench

- Synthesizable OBI responder that serves hyperspectral pixel data to the hsid_x_top OBI initiator.
- Read data is a deterministic function of the request address, so a bench can predict every pixel that hsid_x_top fetches.
- Supports configurable pseudo-random grant back-pressure and a fixed response latency, to stress the initiator's handshake.
- Sits on the hsid_x_top OBI master port in simulation and FPGA bring-up, in place of system memory.

---
 rtl/hsid_obi_pixel_responder.sv | 134 +++++++++++++
 tb/tb_hsid_obi_pixel_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hsid_obi_pixel_responder.sv
// OBI responder serving address-derived pixel words; rvalid RSP_LATENCY cycles after the grant edge.
// Backpressure: grant optionally gated by an LFSR; no rready, responses never stall.
package hsid_x_obi_inf_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module hsid_obi_pixel_responder #(
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [WORD_WIDTH-1:0] VALUE_MASK  = 32'h00003FFF,
  parameter bit                    RANDOM_GNT  = 1'b1,
  parameter logic [15:0]           LFSR_SEED   = 16'hACE1,
  parameter int                    RSP_LATENCY = 1,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  hsid_x_obi_inf_pkg::obi_req_t  obi_req,
  output hsid_x_obi_inf_pkg::obi_resp_t obi_rsp,
  output logic [CNT_WIDTH-1:0]          rd_count_o,
  output logic [CNT_WIDTH-1:0]          wr_count_o,
  output logic                          busy_o
);

  localparam int NUM_LANES = WORD_WIDTH / DATA_WIDTH;

  if (RSP_LATENCY < 1 || RSP_LATENCY > 4) begin : g_bad_latency
    $error("hsid_obi_pixel_responder: RSP_LATENCY must be within 1..4");
  end
  if (WORD_WIDTH % DATA_WIDTH != 0) begin : g_bad_lanes
    $error("hsid_obi_pixel_responder: WORD_WIDTH must be a multiple of DATA_WIDTH");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("hsid_obi_pixel_responder: LFSR_SEED must be non-zero");
  end

  typedef struct packed {
    logic                  vld;
    logic [WORD_WIDTH-1:0] dat;
  } stage_t;

  logic [15:0]           lfsr_q;
  logic                  lfsr_fb;
  logic                  gnt_allow;
  logic                  gnt;
  logic                  addr_hs;
  logic [DATA_WIDTH-1:0] lane_dat;
  logic [WORD_WIDTH-1:0] rsp_dat;
  stage_t                pipe_q [RSP_LATENCY];
  logic                  unused_req_bits;

  // Free-running so the grant pattern depends only on cycles since reset.
  assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign gnt_allow = RANDOM_GNT ? lfsr_q[0] : 1'b1;
  assign gnt       = obi_req.req & gnt_allow & ~rst;
  assign addr_hs   = obi_req.req & gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end

  assign lane_dat = obi_req.addr[DATA_WIDTH-1:0] & VALUE_MASK[DATA_WIDTH-1:0];

  always_comb begin
    rsp_dat = '0;
    if (!obi_req.we) begin
      rsp_dat = {NUM_LANES{lane_dat}};
    end
  end

  // Data is zeroed on idle slots so rdata reads 0 whenever rvalid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0].vld <= addr_hs;
      pipe_q[0].dat <= addr_hs ? rsp_dat : '0;
      for (int i = 1; i < RSP_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if (addr_hs) begin
      if (obi_req.we) begin
        if (wr_count_o != '1) wr_count_o <= wr_count_o + 1'b1;
      end else begin
        if (rd_count_o != '1) rd_count_o <= rd_count_o + 1'b1;
      end
    end
  end

  always_comb begin
    busy_o = gnt;
    for (int i = 0; i < RSP_LATENCY; i++) begin
      busy_o = busy_o | pipe_q[i].vld;
    end
  end

  always_comb begin
    obi_rsp        = '0;
    obi_rsp.gnt    = gnt;
    obi_rsp.rvalid = pipe_q[RSP_LATENCY-1].vld;
    obi_rsp.rdata  = pipe_q[RSP_LATENCY-1].dat;
  end

  // Write payload and upper address bits carry no meaning for this responder.
  assign unused_req_bits = ^{obi_req.be, obi_req.wdata, obi_req.addr[WORD_WIDTH-1:DATA_WIDTH]};

endmodule

// File: tb/tb_hsid_obi_pixel_responder.sv
// Scoreboard bench: three responders (fixed grant L=1, fixed grant L=3, LFSR grant L=4)
// driven with directed and random OBI traffic, checked against an address-rule model.
module tb_hsid_obi_pixel_responder;
  import hsid_x_obi_inf_pkg::*;

  localparam int N  = 3;
  localparam int CW = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  logic            clk;
  logic            rst_s  [N];
  obi_req_t        req_s  [N];
  obi_resp_t       rsp_s  [N];
  logic [CW-1:0]   rdc    [N];
  logic [CW-1:0]   wrc    [N];
  logic            busy   [N];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  exp_t        exp_q    [N][$];
  logic [15:0] m_lfsr   [N];
  int          rd_n     [N];
  int          wr_n     [N];
  int          last_due [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    hsid_obi_pixel_responder #(
      .RANDOM_GNT (g == 2 ? 1'b1 : 1'b0),
      .RSP_LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .CNT_WIDTH  (CW)
    ) u_dut (
      .clk       (clk),
      .rst       (rst_s[g]),
      .obi_req   (req_s[g]),
      .obi_rsp   (rsp_s[g]),
      .rd_count_o(rdc[g]),
      .wr_count_o(wrc[g]),
      .busy_o    (busy[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic bit rnd_of(input int k);
    return k == 2;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
    logic [31:0] lane;
    lane = addr & 32'h0000_3FFF & 32'h0000_FFFF;
    return (lane << 16) | lane;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | (b << 15);
  endfunction

  function automatic logic [31:0] sat(input int n);
    return (n > 15) ? 32'd15 : 32'(n);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference grant LFSR and cycle count, advanced on the same edges as the DUT.
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < N; k++) begin
      m_lfsr[k] = rst_s[k] ? SEED : lfsr_step(m_lfsr[k]);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < N; k++) begin
      if (rsp_s[k].rvalid) begin
        if (exp_q[k].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rvalid[%0d]: got rvalid=1 rdata=0x%08h, expected no response (cycle %0d)",
                   k, rsp_s[k].rdata, cyc);
        end else begin
          e = exp_q[k].pop_front();
          check($sformatf("rsp_cycle[%0d]", k), 32'(cyc), 32'(e.due));
          check($sformatf("rdata[%0d]", k), rsp_s[k].rdata, e.dat);
        end
      end else if (exp_q[k].size() > 0 && exp_q[k][0].due <= cyc) begin
        e = exp_q[k].pop_front();
        checks++;
        failures++;
        $display("FAIL missing_rvalid[%0d]: got rvalid=0, expected response 0x%08h due cycle %0d (cycle %0d)",
                 k, e.dat, e.due, cyc);
      end
    end
  end

  // Holds the request until the model says it is granted; called and returns on a falling edge.
  task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic eg;
    bit   done;
    done = 0;
    req_s[k].req   = 1'b1;
    req_s[k].we    = we;
    req_s[k].be    = 4'hF;
    req_s[k].addr  = addr;
    req_s[k].wdata = wdata;
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      eg = rnd_of(k) ? m_lfsr[k][0] : 1'b1;
      check($sformatf("gnt[%0d]", k), {31'b0, rsp_s[k].gnt}, {31'b0, eg});
      if (eg) begin
        done = 1;
        exp_q[k].push_back(exp_t'{due: cyc + lat_of(k), dat: we ? 32'h0 : exp_rdata(addr)});
        last_due[k] = cyc + lat_of(k);
        if (we) wr_n[k]++;
        else    rd_n[k]++;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout[%0d]: got no grant in 200 cycles, expected a grant", k);
    end
  endtask

  task automatic drain(input int k);
    req_s[k].req = 1'b0;
    for (int t = 0; t < 6; t++) begin
      #1;
      check($sformatf("busy[%0d]", k), {31'b0, busy[k]}, {31'b0, (last_due[k] >= cyc)});
      @(negedge clk);
    end
    check($sformatf("rd_count[%0d]", k), 32'(rdc[k]), sat(rd_n[k]));
    check($sformatf("wr_count[%0d]", k), 32'(wrc[k]), sat(wr_n[k]));
  endtask

  task automatic reset_state_check(input int k);
    req_s[k].req  = 1'b1;
    req_s[k].addr = 32'h0000_0008;
    #1;
    check($sformatf("rst_gnt[%0d]", k), {31'b0, rsp_s[k].gnt}, 32'h0);
    check($sformatf("rst_rvalid[%0d]", k), {31'b0, rsp_s[k].rvalid}, 32'h0);
    check($sformatf("rst_rdata[%0d]", k), rsp_s[k].rdata, 32'h0);
    check($sformatf("rst_rd_count[%0d]", k), 32'(rdc[k]), 32'h0);
    check($sformatf("rst_wr_count[%0d]", k), 32'(wrc[k]), 32'h0);
    check($sformatf("rst_busy[%0d]", k), {31'b0, busy[k]}, 32'h0);
    req_s[k].req = 1'b0;
  endtask

  task automatic random_traffic(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      txn(k, ($urandom_range(0, 3) == 0), $urandom, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        req_s[k].req = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected the bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;
    for (int k = 0; k < N; k++) begin
      rst_s[k]    = 1'b1;
      req_s[k]    = '0;
      m_lfsr[k]   = SEED;
      rd_n[k]     = 0;
      wr_n[k]     = 0;
      last_due[k] = -1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) reset_state_check(k);
    @(negedge clk);
    for (int k = 0; k < N; k++) rst_s[k] = 1'b0;

    txn(0, 1'b0, 32'h0000_0004, 32'h0);
    txn(0, 1'b0, 32'h0001_0004, 32'h0);
    txn(0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    txn(0, 1'b0, 32'h0000_0100, 32'h0);
    drain(0);

    for (int i = 1; i <= 8; i++) txn(1, 1'b0, 32'(4 * i), 32'h0);
    drain(1);

    start = cyc;
    while (cyc - start < 64) txn(2, ($urandom_range(0, 3) == 0), $urandom, $urandom);
    drain(2);

    txn(2, 1'b0, 32'h0000_0040, 32'h0);
    txn(2, 1'b0, 32'h0000_0044, 32'h0);
    req_s[2].req = 1'b0;
    #2;
    rst_s[2] = 1'b1;
    exp_q[2].delete();
    rd_n[2]     = 0;
    wr_n[2]     = 0;
    last_due[2] = -1;
    repeat (2) begin
      @(negedge clk);
      reset_state_check(2);
    end
    @(negedge clk);
    rst_s[2] = 1'b0;
    random_traffic(2, 20);
    drain(2);

    for (int k = 0; k < N; k++) begin
      random_traffic(k, 24);
      drain(k);
    end

    for (int k = 0; k < N; k++) begin
      check($sformatf("leftover[%0d]", k), 32'(exp_q[k].size()), 32'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
